// File: rtl/comm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comm_ctrl_pkg
// Summary  : State encoding and command/response characters for comm_ctrl.
// Revision : 1.0
// ============================================================================
package comm_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TXMEM = 2'd1,
    S_RXMEM = 2'd2
  } state_e;

  localparam logic [7:0] c_CMD_PING     = "p";
  localparam logic [7:0] c_CMD_STATUS   = "s";
  localparam logic [7:0] c_CMD_READ     = "r";
  localparam logic [7:0] c_CMD_WRITE    = "w";
  localparam logic [7:0] c_CMD_EXEC     = "x";

  localparam logic [7:0] c_RSP_PING     = "P";
  localparam logic [7:0] c_RSP_OK       = "+";
  localparam logic [7:0] c_RSP_NOK      = "-";
  localparam logic [7:0] c_RSP_READ     = "R";
  localparam logic [7:0] c_RSP_WRITE    = "W";
  localparam logic [7:0] c_RSP_EXEC     = "X";
  localparam logic [7:0] c_RSP_BUSY     = "!";
  localparam logic [7:0] c_RSP_UNKNOWN  = "?";
  localparam logic [7:0] c_RSP_END      = "E";
  localparam logic [7:0] c_RSP_CSUM_ERR = "C";

  // Index width that stays legal (>= 1 bit) for a single-entry range.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : comm_ctrl_if
// Summary  : UART byte stream, memory override port and CPU control bundle.
// Revision : 1.0
// ============================================================================
interface comm_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  tx_busy;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  mem_override;
  logic                  mem_rnw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  cpu_start;
  logic                  cpu_running;

  modport master (
    input  rx_data, rx_valid, tx_busy, mem_rdata, cpu_running,
    output tx_data, tx_valid, mem_override, mem_rnw, mem_addr, mem_wdata, cpu_start
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mem_rdata, cpu_running,
    input  tx_data, tx_valid, mem_override, mem_rnw, mem_addr, mem_wdata, cpu_start
  );
endinterface
`default_nettype wire

// File: rtl/comm_ctrl_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : comm_word_packer
// Summary  : Little-endian byte lane insert (assembly) and lane select.
// Revision : 1.0
// ============================================================================
module comm_word_packer
  import comm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [idxWidth(DATA_WIDTH/8)-1:0] i_byteIdx,
  input  logic [DATA_WIDTH-1:0]             i_word,
  input  logic [7:0]                        i_byte,
  input  logic [DATA_WIDTH-1:0]             i_rdWord,
  output logic [DATA_WIDTH-1:0]             o_word,
  output logic [7:0]                        o_byte
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_BIW   = idxWidth(c_BYTES);

  logic [7:0] w_lanes [c_BYTES];

  for (genvar l = 0; l < c_BYTES; l++) begin : g_lane
    assign w_lanes[l]       = i_rdWord[8*l +: 8];
    assign o_word[8*l +: 8] = (i_byteIdx == c_BIW'(l)) ? i_byte : i_word[8*l +: 8];
  end

  always_comb begin
    o_byte = 8'h00;
    for (int l = 0; l < c_BYTES; l++) begin
      if (i_byteIdx == c_BIW'(l)) begin
        o_byte = w_lanes[l];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/comm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comm_ctrl
// Summary  : UART command controller: ping/status/exec plus bulk memory
//            read/write. Optional macro COMM_CTRL_CHECKSUM_EN adds an XOR
//            checksum terminator to memory transfers.
// Revision : 1.0
// ============================================================================
module comm_ctrl
  import comm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  comm_ctrl_if.master bus
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_BIW   = idxWidth(c_BYTES);
  localparam int c_IW    = $clog2(MEM_DEPTH + 1);

  localparam logic [1:0] c_IDLE  = S_IDLE;
  localparam logic [1:0] c_TXMEM = S_TXMEM;
  localparam logic [1:0] c_RXMEM = S_RXMEM;

  logic [1:0]            r_state;
  logic [c_IW-1:0]       r_wordIdx;
  logic [c_BIW-1:0]      r_byteIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_txValid;
  logic [7:0]            r_txData;
  logic                  r_memOverride;
  logic                  r_memRnw;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic                  r_cpuStart;
`ifdef COMM_CTRL_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_accept;
  logic                  w_lastByte;
  logic                  w_wordsDone;
  logic [c_IW-1:0]       w_wordIdxNext;
  logic [DATA_WIDTH-1:0] w_packedWord;
  logic [7:0]            w_rdByte;

  // A byte is only taken when the previous response has been handed over.
  assign w_accept      = bus.rx_valid && !r_txValid && !bus.tx_busy;
  assign w_lastByte    = (r_byteIdx == c_BIW'(c_BYTES - 1));
  assign w_wordsDone   = (r_wordIdx == c_IW'(MEM_DEPTH));
  assign w_wordIdxNext = r_wordIdx + c_IW'(1);

  comm_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .i_byteIdx (r_byteIdx),
    .i_word    (r_shift),
    .i_byte    (bus.rx_data),
    .i_rdWord  (bus.mem_rdata),
    .o_word    (w_packedWord),
    .o_byte    (w_rdByte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_wordIdx     <= '0;
      r_byteIdx     <= '0;
      r_shift       <= '0;
      r_txValid     <= 1'b0;
      r_txData      <= 8'h00;
      r_memOverride <= 1'b0;
      r_memRnw      <= 1'b1;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_cpuStart    <= 1'b0;
`ifdef COMM_CTRL_CHECKSUM_EN
      r_csum        <= 8'h00;
`endif
    end else begin
      r_cpuStart <= 1'b0;
      r_memRnw   <= 1'b1;
      if (bus.tx_busy) begin
        r_txValid <= 1'b0;
      end

      if (w_accept) begin
        r_txValid <= 1'b1;
        case (r_state)
          c_IDLE: begin
            case (bus.rx_data)
              c_CMD_PING:   r_txData <= c_RSP_PING;
              c_CMD_STATUS: r_txData <= bus.cpu_running ? c_RSP_OK : c_RSP_NOK;
              c_CMD_READ, c_CMD_WRITE: begin
                r_txData      <= (bus.rx_data == c_CMD_READ) ? c_RSP_READ : c_RSP_WRITE;
                r_state       <= (bus.rx_data == c_CMD_READ) ? c_TXMEM : c_RXMEM;
                r_memOverride <= 1'b1;
                r_memAddr     <= '0;
                r_wordIdx     <= '0;
                r_byteIdx     <= '0;
`ifdef COMM_CTRL_CHECKSUM_EN
                r_csum        <= 8'h00;
`endif
              end
              c_CMD_EXEC: begin
                r_txData   <= bus.cpu_running ? c_RSP_BUSY : c_RSP_EXEC;
                r_cpuStart <= !bus.cpu_running;
              end
              default:      r_txData <= c_RSP_UNKNOWN;
            endcase
          end

          c_TXMEM: begin
            if (w_wordsDone) begin
`ifdef COMM_CTRL_CHECKSUM_EN
              r_txData      <= r_csum;
`else
              r_txData      <= c_RSP_END;
`endif
              r_state       <= c_IDLE;
              r_memOverride <= 1'b0;
              r_memAddr     <= '0;
              r_wordIdx     <= '0;
              r_byteIdx     <= '0;
            end else begin
              r_txData <= w_rdByte;
`ifdef COMM_CTRL_CHECKSUM_EN
              r_csum   <= r_csum ^ w_rdByte;
`endif
              // Address moves ahead early so read data is settled for the next byte.
              if (w_lastByte) begin
                r_byteIdx <= '0;
                r_wordIdx <= w_wordIdxNext;
                r_memAddr <= ADDR_WIDTH'(w_wordIdxNext);
              end else begin
                r_byteIdx <= r_byteIdx + c_BIW'(1);
              end
            end
          end

          c_RXMEM: begin
            if (w_wordsDone) begin
`ifdef COMM_CTRL_CHECKSUM_EN
              r_txData      <= (bus.rx_data == r_csum) ? c_RSP_END : c_RSP_CSUM_ERR;
`else
              r_txData      <= c_RSP_END;
`endif
              r_state       <= c_IDLE;
              r_memOverride <= 1'b0;
              r_memAddr     <= '0;
              r_wordIdx     <= '0;
              r_byteIdx     <= '0;
            end else begin
              r_shift <= w_packedWord;
`ifdef COMM_CTRL_CHECKSUM_EN
              r_csum  <= r_csum ^ bus.rx_data;
`endif
              if (w_lastByte) begin
                r_txData   <= c_RSP_NOK;
                r_memRnw   <= 1'b0;
                r_memWdata <= w_packedWord;
                r_memAddr  <= ADDR_WIDTH'(r_wordIdx);
                r_wordIdx  <= w_wordIdxNext;
                r_byteIdx  <= '0;
              end else begin
                r_txData   <= c_RSP_OK;
                r_byteIdx  <= r_byteIdx + c_BIW'(1);
              end
            end
          end

          default: begin
            r_txData      <= c_RSP_UNKNOWN;
            r_state       <= c_IDLE;
            r_memOverride <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_valid     = r_txValid;
  assign bus.tx_data      = r_txData;
  assign bus.mem_override = r_memOverride;
  assign bus.mem_rnw      = r_memRnw;
  assign bus.mem_addr     = r_memAddr;
  assign bus.mem_wdata    = r_memWdata;
  assign bus.cpu_start    = r_cpuStart;

endmodule
`default_nettype wire

// File: tb/tb_comm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_comm_ctrl
// Summary  : Self-checking bench: 16-bit/4-word and 32-bit/1-word instances.
// Revision : 1.0
// ============================================================================
module tb_comm_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comm_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus16 ();
  comm_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus32 ();

  comm_ctrl #(.DATA_WIDTH(16), .MEM_DEPTH(4), .ADDR_WIDTH(16)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );
  comm_ctrl #(.DATA_WIDTH(32), .MEM_DEPTH(1), .ADDR_WIDTH(16)) dut32 (
    .clk (clk), .rst (rst), .bus (bus32)
  );

  int nChecks = 0;
  int nFail   = 0;
  int startCnt = 0;
  int startBad = 0;

  logic [15:0] mem16 [8];
  logic [31:0] mem32 [2];
  logic [15:0] wrAddr16 [$];
  logic [15:0] wrData16 [$];
  logic [15:0] wrAddr32 [$];
  logic [31:0] wrData32 [$];

  logic [7:0]  pay   [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  logic [15:0] words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  // Memory model: synchronous read one cycle after the address, logged writes.
  always @(posedge clk) begin
    bus16.mem_rdata <= mem16[bus16.mem_addr[2:0]];
    bus32.mem_rdata <= mem32[bus32.mem_addr[0]];
    if (!rst && bus16.mem_override && !bus16.mem_rnw) begin
      mem16[bus16.mem_addr[2:0]] <= bus16.mem_wdata;
      wrAddr16.push_back(bus16.mem_addr);
      wrData16.push_back(bus16.mem_wdata);
    end
    if (!rst && bus32.mem_override && !bus32.mem_rnw) begin
      mem32[bus32.mem_addr[0]] <= bus32.mem_wdata;
      wrAddr32.push_back(bus32.mem_addr);
      wrData32.push_back(bus32.mem_wdata);
    end
    if (bus16.cpu_start) begin
      startCnt <= startCnt + 1;
      if (bus16.mem_override) startBad <= startBad + 1;
    end
  end

  task automatic setRx(input bit w, input logic [7:0] b, input logic v);
    if (w) begin bus32.rx_data = b; bus32.rx_valid = v; end
    else   begin bus16.rx_data = b; bus16.rx_valid = v; end
  endtask

  task automatic setBusy(input bit w, input logic v);
    if (w) bus32.tx_busy = v; else bus16.tx_busy = v;
  endtask

  function automatic logic txValid(input bit w);
    return w ? bus32.tx_valid : bus16.tx_valid;
  endfunction

  function automatic logic [7:0] txData(input bit w);
    return w ? bus32.tx_data : bus16.tx_data;
  endfunction

  // Offer one byte, then hold the response for 'hold' idle cycles before a busy pulse.
  // ok reports whether the tx_valid handshake timing was as expected.
  task automatic sendByte(input bit w, input logic [7:0] b, input int hold,
                          output logic [7:0] rsp, output bit ok);
    ok = 1'b1;
    @(negedge clk); setRx(w, b, 1'b1);
    @(negedge clk); setRx(w, 8'h00, 1'b0);
    if (!txValid(w)) ok = 1'b0;
    rsp = txData(w);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!txValid(w) || txData(w) !== rsp) ok = 1'b0;
    end
    setBusy(w, 1'b1);
    @(negedge clk);
    if (txValid(w)) ok = 1'b0;
    setBusy(w, 1'b0);
  endtask

  function automatic logic [7:0] expIdle(input logic [7:0] b, input logic run);
    case (b)
      "p":     return "P";
      "s":     return run ? "+" : "-";
      default: return "?";
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({bus16.tx_valid, bus16.tx_data, bus16.mem_override, bus16.mem_rnw, bus16.mem_addr,
         bus16.mem_wdata, bus16.cpu_start} !== {1'b0, 8'h00, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0}) begin
      nFail++;
      $display("FAIL reset16: got v=%b d=%h ov=%b rnw=%b a=%h wd=%h st=%b", bus16.tx_valid,
               bus16.tx_data, bus16.mem_override, bus16.mem_rnw, bus16.mem_addr,
               bus16.mem_wdata, bus16.cpu_start);
    end
    nChecks++;
    if ({bus32.tx_valid, bus32.tx_data, bus32.mem_override, bus32.mem_rnw, bus32.mem_addr,
         bus32.mem_wdata, bus32.cpu_start} !== {1'b0, 8'h00, 1'b0, 1'b1, 16'h0, 32'h0, 1'b0}) begin
      nFail++;
      $display("FAIL reset32: got v=%b d=%h ov=%b rnw=%b a=%h wd=%h", bus32.tx_valid,
               bus32.tx_data, bus32.mem_override, bus32.mem_rnw, bus32.mem_addr, bus32.mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ping_hold;
    logic [7:0] rsp; bit ok;
    sendByte(1'b0, "p", 10, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h50}) begin
      nFail++; $display("FAIL ping_hold: got ok=%b rsp=%h want ok=1 rsp=50", ok, rsp);
    end
  endtask

  task automatic test_write;
    logic [7:0] rsp; bit ok; logic [7:0] exp;
    wrAddr16.delete(); wrData16.delete();
    sendByte(1'b0, "w", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h57}) begin
      nFail++; $display("FAIL write_cmd: got ok=%b rsp=%h want 57", ok, rsp);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 1) ? "-" : "+";
      sendByte(1'b0, pay[i], $urandom_range(0, 2), rsp, ok);
      nChecks++;
      if ({ok, rsp} !== {1'b1, exp}) begin
        nFail++; $display("FAIL write_byte%0d: got ok=%b rsp=%h want %h", i, ok, rsp, exp);
      end
    end
    sendByte(1'b0, 8'h00, 0, rsp, ok);
    nChecks++;
    if ({ok, rsp, bus16.mem_override} !== {1'b1, 8'h45, 1'b0}) begin
      nFail++; $display("FAIL write_term: got ok=%b rsp=%h ov=%b want 45 ov=0", ok, rsp, bus16.mem_override);
    end
    nChecks++;
    if (wrAddr16.size() != 4) begin
      nFail++; $display("FAIL write_count: got %0d want 4", wrAddr16.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ga, gd;
      ga = (i < wrAddr16.size()) ? wrAddr16[i] : 16'hFFFF;
      gd = (i < wrData16.size()) ? wrData16[i] : 16'hFFFF;
      nChecks++;
      if ({ga, gd} !== {16'(i), words[i]}) begin
        nFail++; $display("FAIL write_word%0d: got a=%h d=%h want a=%h d=%h", i, ga, gd, i, words[i]);
      end
    end
  endtask

  task automatic test_read;
    logic [7:0] rsp; bit ok; logic [7:0] expTerm;
`ifdef COMM_CTRL_CHECKSUM_EN
    expTerm = 8'h00;
`else
    expTerm = "E";
`endif
    sendByte(1'b0, "r", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp, bus16.mem_override, bus16.mem_rnw, bus16.mem_addr} !== {1'b1, 8'h52, 1'b1, 1'b1, 16'h0}) begin
      nFail++; $display("FAIL read_cmd: got ok=%b rsp=%h ov=%b rnw=%b a=%h", ok, rsp,
                        bus16.mem_override, bus16.mem_rnw, bus16.mem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      sendByte(1'b0, 8'($urandom), $urandom_range(0, 2), rsp, ok);
      nChecks++;
      if ({ok, rsp} !== {1'b1, pay[i]}) begin
        nFail++; $display("FAIL read_byte%0d: got ok=%b rsp=%h want %h", i, ok, rsp, pay[i]);
      end
    end
    sendByte(1'b0, 8'($urandom), 0, rsp, ok);
    nChecks++;
    if ({ok, rsp, bus16.mem_override} !== {1'b1, expTerm, 1'b0}) begin
      nFail++; $display("FAIL read_term: got ok=%b rsp=%h ov=%b want %h ov=0", ok, rsp, bus16.mem_override, expTerm);
    end
  endtask

  task automatic test_cpu;
    logic [7:0] rsp; bit ok; int s0;
    bus16.cpu_running = 1'b0;
    s0 = startCnt;
    sendByte(1'b0, "x", 1, rsp, ok);
    nChecks++;
    if ({ok, rsp, startCnt - s0} !== {1'b1, 8'h58, 32'sd1}) begin
      nFail++; $display("FAIL exec_idle: got ok=%b rsp=%h pulses=%0d want 58 pulses=1", ok, rsp, startCnt - s0);
    end
    bus16.cpu_running = 1'b1;
    s0 = startCnt;
    sendByte(1'b0, "x", 1, rsp, ok);
    nChecks++;
    if ({ok, rsp, startCnt - s0} !== {1'b1, 8'h21, 32'sd0}) begin
      nFail++; $display("FAIL exec_busy: got ok=%b rsp=%h pulses=%0d want 21 pulses=0", ok, rsp, startCnt - s0);
    end
    sendByte(1'b0, "s", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h2B}) begin
      nFail++; $display("FAIL status_run: got ok=%b rsp=%h want 2b", ok, rsp);
    end
    bus16.cpu_running = 1'b0;
    sendByte(1'b0, "s", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h2D}) begin
      nFail++; $display("FAIL status_idle: got ok=%b rsp=%h want 2d", ok, rsp);
    end
  endtask

  task automatic test_drop;
    logic [7:0] rsp; bit ok; int s0; int rises;
    s0 = startCnt;
    @(negedge clk); setRx(1'b0, "p", 1'b1);
    @(negedge clk); setRx(1'b0, 8'h00, 1'b0);
    // Offered while a response is still pending: must be ignored.
    setRx(1'b0, "x", 1'b1);
    @(negedge clk); setRx(1'b0, 8'h00, 1'b0);
    nChecks++;
    if ({bus16.tx_valid, bus16.tx_data} !== {1'b1, 8'h50}) begin
      nFail++; $display("FAIL drop_pending: got v=%b d=%h want v=1 d=50", bus16.tx_valid, bus16.tx_data);
    end
    setBusy(1'b0, 1'b1);
    @(negedge clk);
    setRx(1'b0, "w", 1'b1);
    @(negedge clk); setRx(1'b0, 8'h00, 1'b0); setBusy(1'b0, 1'b0);
    rises = 0;
    repeat (5) begin @(negedge clk); if (bus16.tx_valid) rises++; end
    nChecks++;
    if ({rises, startCnt - s0} !== {32'sd0, 32'sd0}) begin
      nFail++; $display("FAIL drop_extra: got rsp_cycles=%0d pulses=%0d want 0 0", rises, startCnt - s0);
    end
    sendByte(1'b0, "p", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h50}) begin
      nFail++; $display("FAIL drop_state: got ok=%b rsp=%h want 50", ok, rsp);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rsp; bit ok;
    wrAddr16.delete(); wrData16.delete();
    sendByte(1'b0, "w", 0, rsp, ok);
    sendByte(1'b0, 8'h34, 0, rsp, ok);
    sendByte(1'b0, 8'h12, 0, rsp, ok);
    @(negedge clk); setRx(1'b0, 8'h78, 1'b1);
    @(negedge clk); setRx(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({bus16.tx_valid, bus16.mem_override, bus16.mem_rnw, 32'(wrAddr16.size())} !== {1'b0, 1'b0, 1'b1, 32'd1}) begin
      nFail++; $display("FAIL rst_mid: got v=%b ov=%b rnw=%b writes=%0d want 0 0 1 1", bus16.tx_valid,
                        bus16.mem_override, bus16.mem_rnw, wrAddr16.size());
    end
    sendByte(1'b0, "p", 0, rsp, ok);
    nChecks++;
    if ({ok, rsp} !== {1'b1, 8'h50}) begin
      nFail++; $display("FAIL rst_mid_ping: got ok=%b rsp=%h want 50", ok, rsp);
    end
  endtask

  task automatic test_random;
    logic [15:0] expMem [4];
    logic [7:0] rsp; bit ok; logic [7:0] b; logic [7:0] exp; logic [7:0] csum; logic run;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        if (b == "r" || b == "w" || b == "x") b = "s";
        run = 1'($urandom_range(0, 1));
        bus16.cpu_running = run;
        sendByte(1'b0, b, $urandom_range(0, 3), rsp, ok);
        nChecks++;
        if ({ok, rsp} !== {1'b1, expIdle(b, run)}) begin
          nFail++; $display("FAIL rnd_idle: cmd=%h got ok=%b rsp=%h want %h", b, ok, rsp, expIdle(b, run));
        end
      end
      bus16.cpu_running = 1'b0;
      for (int wd = 0; wd < 4; wd++) expMem[wd] = 16'($urandom);
      wrAddr16.delete(); wrData16.delete();
      sendByte(1'b0, "w", 0, rsp, ok);
      csum = 8'h00;
      for (int wd = 0; wd < 4; wd++) begin
        for (int k = 0; k < 2; k++) begin
          b = expMem[wd][8*k +: 8];
          csum ^= b;
          exp = (k == 1) ? "-" : "+";
          sendByte(1'b0, b, $urandom_range(0, 3), rsp, ok);
          nChecks++;
          if ({ok, rsp} !== {1'b1, exp}) begin
            nFail++; $display("FAIL rnd_wr: w%0d b%0d got ok=%b rsp=%h want %h", wd, k, ok, rsp, exp);
          end
        end
      end
      sendByte(1'b0, csum, 0, rsp, ok);
      nChecks++;
      if ({ok, rsp} !== {1'b1, 8'h45}) begin
        nFail++; $display("FAIL rnd_wr_term: got ok=%b rsp=%h want 45", ok, rsp);
      end
      for (int wd = 0; wd < 4; wd++) begin
        nChecks++;
        if (wd >= wrAddr16.size() || {wrAddr16[wd], wrData16[wd]} !== {16'(wd), expMem[wd]}) begin
          nFail++; $display("FAIL rnd_wr_mem: word %0d of %0d writes, want a=%h d=%h", wd, wrAddr16.size(), wd, expMem[wd]);
        end
      end
      sendByte(1'b0, "r", 0, rsp, ok);
      for (int wd = 0; wd < 4; wd++) begin
        for (int k = 0; k < 2; k++) begin
          sendByte(1'b0, 8'($urandom), $urandom_range(0, 3), rsp, ok);
          nChecks++;
          if ({ok, rsp} !== {1'b1, expMem[wd][8*k +: 8]}) begin
            nFail++; $display("FAIL rnd_rd: w%0d b%0d got ok=%b rsp=%h want %h", wd, k, ok, rsp, expMem[wd][8*k +: 8]);
          end
        end
      end
`ifdef COMM_CTRL_CHECKSUM_EN
      exp = csum;
`else
      exp = "E";
`endif
      sendByte(1'b0, 8'($urandom), 0, rsp, ok);
      nChecks++;
      if ({ok, rsp, bus16.mem_override} !== {1'b1, exp, 1'b0}) begin
        nFail++; $display("FAIL rnd_rd_term: got ok=%b rsp=%h ov=%b want %h", ok, rsp, bus16.mem_override, exp);
      end
    end
  endtask

  task automatic test_wide;
    logic [7:0] rsp; bit ok; logic [7:0] exp; logic [7:0] term;
    wrAddr32.delete(); wrData32.delete();
    for (int pass = 0; pass < 2; pass++) begin
      sendByte(1'b1, "w", 0, rsp, ok);
      nChecks++;
      if ({ok, rsp} !== {1'b1, 8'h57}) begin
        nFail++; $display("FAIL wide_cmd: got ok=%b rsp=%h want 57", ok, rsp);
      end
      for (int i = 1; i <= 4; i++) begin
        exp = (i == 4) ? "-" : "+";
        sendByte(1'b1, 8'(i), $urandom_range(0, 2), rsp, ok);
        nChecks++;
        if ({ok, rsp} !== {1'b1, exp}) begin
          nFail++; $display("FAIL wide_byte%0d: got ok=%b rsp=%h want %h", i, ok, rsp, exp);
        end
      end
      term = (pass == 0) ? 8'h05 : 8'h04;
`ifdef COMM_CTRL_CHECKSUM_EN
      exp = (pass == 0) ? "C" : "E";
`else
      exp = "E";
`endif
      sendByte(1'b1, term, 0, rsp, ok);
      nChecks++;
      if ({ok, rsp, bus32.mem_override} !== {1'b1, exp, 1'b0}) begin
        nFail++; $display("FAIL wide_term%0d: got ok=%b rsp=%h ov=%b want %h ov=0", pass, ok, rsp, bus32.mem_override, exp);
      end
    end
    nChecks++;
    if (wrAddr32.size() != 2 || {wrAddr32[0], wrData32[0], wrAddr32[1], wrData32[1]} !==
        {16'h0, 32'h04030201, 16'h0, 32'h04030201}) begin
      nFail++; $display("FAIL wide_mem: got %0d writes, want 2 x a=0 d=04030201", wrAddr32.size());
    end
    nChecks++;
    if (startBad != 0) begin
      nFail++; $display("FAIL start_overlap: got %0d pulses with mem_override, want 0", startBad);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus16.rx_data = 8'h00; bus16.rx_valid = 1'b0; bus16.tx_busy = 1'b0; bus16.cpu_running = 1'b0;
    bus32.rx_data = 8'h00; bus32.rx_valid = 1'b0; bus32.tx_busy = 1'b0; bus32.cpu_running = 1'b0;
    test_reset;
    test_ping_hold;
    test_write;
    test_read;
    test_cpu;
    test_drop;
    test_reset_mid;
    test_random;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", nChecks, nFail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/comm_ctrl.md
COMM_CTRL -- requirements
Module: comm_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, memory word width in bits, an integer multiple of 8, range 8..64.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 32, number of words transferred by 'r'/'w', range 1..2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 16, memory address width in bits.
REQ-004 The block SHALL have port clk  in  1  single clock for all logic.
REQ-005 The block SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 The block SHALL have port rx_data  in  8  received UART byte, valid while rx_valid=1.
REQ-007 The block SHALL have port rx_valid  in  1  single-cycle pulse marking a new received byte.
REQ-008 The block SHALL have port tx_busy  in  1  UART transmitter busy; its first high cycle acknowledges tx_valid.
REQ-009 The block SHALL have port tx_data  out  8  response byte, stable while tx_valid=1.
REQ-010 The block SHALL have port tx_valid  out  1  response byte pending.
REQ-011 The block SHALL have port mem_override  out  1  block owns the memory port.
REQ-012 The block SHALL have port mem_rnw  out  1  1 = read, 0 = write.
REQ-013 The block SHALL have port mem_addr  out  ADDR_WIDTH  word address.
REQ-014 The block SHALL have port mem_wdata  out  DATA_WIDTH  write data.
REQ-015 The block SHALL have port mem_rdata  in  DATA_WIDTH  read data, valid one cycle after mem_addr.
REQ-016 The block SHALL have port cpu_start  out  1  one-cycle pulse that starts execution at address 0.
REQ-017 The block SHALL have port cpu_running  in  1  execution state machine busy.

Function
REQ-018 The block SHALL accept a byte only when rx_valid=1, tx_valid=0 and tx_busy=0; any other rx_valid byte SHALL be dropped without a state change.
REQ-019 Every accepted byte SHALL produce exactly one response byte, with tx_valid rising the cycle after acceptance.
REQ-020 tx_valid SHALL clear in the first cycle tx_busy=1 and SHALL remain set indefinitely while tx_busy=0.
REQ-021 The state machine SHALL have the states IDLE, TXMEM and RXMEM.
REQ-022 In IDLE, the commands SHALL behave as follows: 'p' -> "P"; 's' -> "+" if cpu_running else "-"; 'r' -> "R", word index 0, enter TXMEM; 'w' -> "W", word index 0, enter RXMEM.
REQ-023 In IDLE, 'x' SHALL respond "X" and pulse cpu_start for one cycle if cpu_running=0, and SHALL respond "!" with no pulse otherwise.
REQ-024 In IDLE, any other byte SHALL respond "?".
REQ-025 With BYTES=DATA_WIDTH/8, words SHALL be carried little-endian, least-significant byte first.
REQ-026 In TXMEM, mem_override=1, mem_rnw=1 and mem_addr=word index SHALL be driven from the cycle TXMEM is entered.
REQ-027 In TXMEM, each accepted byte, of any value, SHALL return the next byte of mem_rdata; the byte index SHALL advance, and the word index SHALL advance after byte BYTES-1.
REQ-028 In TXMEM, after MEM_DEPTH words the next accepted byte SHALL respond "E", drop mem_override and return to IDLE.
REQ-029 In RXMEM, each accepted byte SHALL be shifted into its little-endian lane; bytes 0..BYTES-2 SHALL respond "+".
REQ-030 In RXMEM, byte BYTES-1 SHALL respond "-" and drive mem_override=1, mem_rnw=0, mem_addr=index and the assembled mem_wdata for exactly one cycle, after which mem_rnw SHALL return to 1.
REQ-031 In RXMEM, after MEM_DEPTH words the next accepted byte SHALL respond "E", drop mem_override and return to IDLE.
REQ-032 The word index SHALL be ceil(log2(MEM_DEPTH+1)) bits wide and SHALL never wrap; mem_addr SHALL be the index zero-extended to ADDR_WIDTH.
REQ-033 In IDLE, mem_override SHALL be 0.
REQ-034 cpu_start SHALL never assert while mem_override=1.

Reset
REQ-035 While rst=1 the block SHALL enter IDLE and set tx_valid=0, tx_data=0, mem_override=0, mem_rnw=1, mem_addr=0, mem_wdata=0, cpu_start=0, and clear the word index, byte index and checksum.
REQ-036 A reset asserted mid-transfer SHALL abort it with no further memory write, and a pending response SHALL be discarded.

Configuration
REQ-037 With COMM_CTRL_CHECKSUM_EN defined, an 8-bit XOR checksum of all payload bytes SHALL be kept per transfer.
REQ-038 With COMM_CTRL_CHECKSUM_EN defined, the TXMEM terminator SHALL return the checksum in place of "E".
REQ-039 With COMM_CTRL_CHECKSUM_EN defined, the RXMEM terminator byte SHALL be compared with the checksum, responding "E" on a match and "C" on a mismatch; already-written words SHALL be retained.
REQ-040 Without COMM_CTRL_CHECKSUM_EN, the checksum logic SHALL be absent and the terminators SHALL behave as in REQ-028 and REQ-031.

Structure
REQ-041 Package comm_ctrl_pkg SHALL hold the state enum and the response and command character constants.
REQ-042 Sub-module comm_word_packer SHALL perform parametrised byte-to-word assembly and word-to-byte selection, indexed by the byte index.

Verification
REQ-043 The bench SHALL check: rx 'p', tx_busy held 0 for 10 cycles -> tx_valid stays 1 with "P"; tx_busy pulse -> tx_valid clears next cycle.
REQ-044 The bench SHALL check, for DATA_WIDTH=16, MEM_DEPTH=4: 'w' then bytes 34 12 78 56 BC 9A F0 DE -> writes 0x1234, 0x5678, 0x9ABC, 0xDEF0 at addresses 0..3; responses "W+-+-+-+-".
REQ-045 The bench SHALL check: a following 'r' plus 9 pacing bytes -> "R", 34 12 78 56 BC 9A F0 DE, then "E" (or checksum 0x00 with COMM_CTRL_CHECKSUM_EN) and mem_override=0.
REQ-046 The bench SHALL check: 'x' with cpu_running=0 -> "X" and one cpu_start pulse; 'x' with cpu_running=1 -> "!" and no pulse; 's' -> "+".
REQ-047 The bench SHALL check: rx_valid while tx_valid=1 -> byte dropped, no extra response.
REQ-048 The bench SHALL check: rst asserted after the 3rd 'w' payload byte -> IDLE, mem_override=0, exactly one write issued; a following 'p' -> "P".
REQ-049 The bench SHALL check, for DATA_WIDTH=32, MEM_DEPTH=1 and COMM_CTRL_CHECKSUM_EN: 'w' 01 02 03 04 then 0x05 -> "C"; repeated with 0x04 -> "E".
